// File: rtl/fifo_nibble_packer_if.sv
// FIFO-drain and packed-output handshake bundle
// master = packer side, slave = FIFO/consumer side
interface fifo_nibble_packer_if #(
  parameter int IN_W  = 4,
  parameter int PACK  = 2,
  parameter int CNT_W = 16
);
  localparam int OUT_W = IN_W * PACK;

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [IN_W-1:0]  fifo_data;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] word_count;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, word_count
  );

  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, word_count
  );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Drains a synchronous FIFO and packs PACK words LSB-first
// into one output word behind a one-entry valid/ready register
module fifo_nibble_packer #(
  parameter int IN_W  = 4,
  parameter int PACK  = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  fifo_nibble_packer_if.master bus
);
  localparam int OUT_W = IN_W * PACK;
  localparam int CW    = $clog2(PACK + 1);
  localparam logic [CW:0]   LP_PACK = (CW+1)'(PACK);
  localparam logic [CW-1:0] LP_FULL = CW'(PACK);

  logic [OUT_W-1:0] r_acc;
  logic             r_acc_last;
  logic [CW-1:0]    r_cnt;
  logic             r_pend;
  logic             r_flush_req;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [CNT_W-1:0] r_word_count;

  logic          w_full;
  logic          w_xfer;
  logic          w_room;
  logic          w_rd_en;
  logic          w_take;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_slot;

  // a read is only issued when its data is sure to have a slot
  assign w_full  = (r_cnt == LP_FULL);
  assign w_xfer  = w_full && (!r_out_valid || bus.out_ready);
  assign w_used  = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_room  = (w_used < LP_PACK) || (w_xfer && !r_pend);
  assign w_rd_en = !reset && !bus.fifo_empty && !r_flush_req && w_room;
  assign w_take  = r_out_valid && bus.out_ready;
  assign w_slot  = w_xfer ? '0 : r_cnt;

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.word_count = r_word_count;

  // accumulator, flush sequencing and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_acc_last   <= 1'b0;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_flush_req  <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_pend <= w_rd_en;

      if (w_take)
        r_word_count <= r_word_count + 1'b1;

      if (w_xfer) begin
        r_out_data  <= r_acc;
        r_out_valid <= 1'b1;
        r_out_last  <= r_acc_last;
        r_acc       <= '0;
        r_acc_last  <= 1'b0;
        r_cnt       <= '0;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (r_pend) begin
        for (int i = 0; i < PACK; i++)
          if (w_slot == CW'(i))
            r_acc[i*IN_W +: IN_W] <= bus.fifo_data;
        r_cnt <= w_slot + 1'b1;
      end

      // slots above cnt are always zero, so a partial word
      // only needs to be marked full and tagged last
      if (!r_flush_req) begin
        if (bus.flush)
          r_flush_req <= 1'b1;
      end else if (!r_pend) begin
        r_flush_req <= 1'b0;
        if (r_cnt != '0 && !w_full) begin
          r_cnt      <= LP_FULL;
          r_acc_last <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: queue-based FIFO model
// and a packing scoreboard built from the written nibbles
module tb_fifo_nibble_packer;
  localparam int IN_W  = 4;
  localparam int PACK  = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;

  fifo_nibble_packer_if #(.IN_W(IN_W), .PACK(PACK), .CNT_W(CNT_W)) bus ();

  fifo_nibble_packer #(.IN_W(IN_W), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [IN_W-1:0] mem [0:4095];
  int wr_n = 0;
  int rd_n = 0;
  int rd_seen = 0;
  int wc_exp = 0;

  logic [IN_W-1:0]   nb_q [$];
  logic [IN_W*PACK-1:0] exp_d [$];
  logic              exp_l [$];

  assign bus.fifo_empty = (wr_n == rd_n);

  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_data <= mem[rd_n];
      rd_n <= rd_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic last);
    logic [IN_W*PACK-1:0] w;
    w = '0;
    foreach (nb_q[i]) w[i*IN_W +: IN_W] = nb_q[i];
    exp_d.push_back(w);
    exp_l.push_back(last);
    nb_q.delete();
  endtask

  task automatic wr(input logic [IN_W-1:0] v);
    mem[wr_n] = v;
    wr_n++;
    nb_q.push_back(v);
    if (nb_q.size() == PACK) push_word(1'b0);
  endtask

  task automatic model_flush();
    if (nb_q.size() > 0) push_word(1'b1);
  endtask

  task automatic model_clear();
    nb_q.delete();
    exp_d.delete();
    exp_l.delete();
    wc_exp = 0;
  endtask

  // checks the current cycle, then advances to the next negedge
  task automatic cyc();
    #1;
    chk("rd_while_empty", {31'd0, bus.fifo_rd_en && bus.fifo_empty}, 0);
    if (reset) chk("rd_in_reset", {31'd0, bus.fifo_rd_en}, 0);
    if (bus.fifo_rd_en && !bus.fifo_empty) rd_seen++;
    if (!reset) chk("word_count", {28'd0, bus.word_count}, wc_exp);
    if (bus.out_valid === 1'b1) begin
      if (exp_d.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_d[0]});
        chk("out_last", {31'd0, bus.out_last}, {31'd0, exp_l[0]});
        if (bus.out_ready && !reset) begin
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          wc_exp = (wc_exp + 1) % (1 << CNT_W);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_d.size() > 0 || wr_n != rd_n) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", {31'd0, n >= budget}, 0);
    cyc();
    cyc();
  endtask

  task automatic quiesce_flush();
    int n = 0;
    while (wr_n != rd_n && n < 200) begin
      bus.out_ready = ($urandom_range(3) != 0);
      cyc();
      n++;
    end
    chk("empty_timeout", {31'd0, n >= 200}, 0);
    repeat (3) cyc();
    bus.flush = 1'b1;
    model_flush();
    cyc();
    bus.flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_data", {24'd0, bus.out_data}, 0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_last", {31'd0, bus.out_last}, 0);
    chk("rst_word_count", {28'd0, bus.word_count}, 0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    reset = 1'b0;

    // flush on an empty FIFO
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    wr(4'h5);
    #1;
    chk("flush_blocks_rd", {31'd0, bus.fifo_rd_en}, 0);
    chk("flush_no_valid", {31'd0, bus.out_valid}, 0);
    cyc();
    #1;
    chk("rd_after_flush", {31'd0, bus.fifo_rd_en}, 1);
    wr(4'h6);
    bus.out_ready = 1'b1;
    drain(100);

    // plain stream
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) wr(IN_W'(i));
    drain(100);
    chk("t1_word_count", {28'd0, bus.word_count}, 4);

    // back-pressure
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(IN_W'(i));
    for (int i = 0; i < 10; i++) begin
      if (i >= 7) chk("bp_no_read", {31'd0, bus.fifo_rd_en}, 0);
      cyc();
    end
    chk("bp_hold", {24'd0, bus.out_data}, 32'h21);
    bus.out_ready = 1'b1;
    drain(100);
    chk("t2_word_count", {28'd0, bus.word_count}, 4);

    // flush of a partial word
    do_reset();
    bus.out_ready = 1'b1;
    wr(4'h1); wr(4'h2); wr(4'h3);
    quiesce_flush();
    bus.out_ready = 1'b1;
    drain(100);
    chk("t3_word_count", {28'd0, bus.word_count}, 2);

    // reset with a read in flight
    do_reset();
    bus.out_ready = 1'b1;
    wr(4'h1); wr(4'h2); wr(4'h3);
    rd_seen = 0;
    for (int n = 0; n < 30 && rd_seen < 3; n++) cyc();
    chk("t5_third_read", rd_seen, 3);
    reset = 1'b1;
    cyc();
    chk("t5_out_data", {24'd0, bus.out_data}, 0);
    chk("t5_out_valid", {31'd0, bus.out_valid}, 0);
    chk("t5_out_last", {31'd0, bus.out_last}, 0);
    chk("t5_word_count", {28'd0, bus.word_count}, 0);
    model_clear();
    wr(4'h9);
    #1;
    chk("t5_rd_in_reset", {31'd0, bus.fifo_rd_en}, 0);
    cyc();
    reset = 1'b0;
    wr(4'hA);
    drain(100);
    chk("t5_post_count", {28'd0, bus.word_count}, 1);

    // word_count wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17 * PACK; i++) wr(IN_W'($urandom_range(15)));
    drain(400);
    chk("t6_wrap", {28'd0, bus.word_count}, 1);

    // random traffic, back-pressure and flushes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1) == 1) wr(IN_W'($urandom_range(15)));
      bus.out_ready = ($urandom_range(3) != 0);
      cyc();
      if (i % 100 == 99) quiesce_flush();
    end
    quiesce_flush();
    bus.out_ready = 1'b1;
    drain(600);
    chk("rand_all_out", exp_d.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
